uart_rx: RTL
============

Name: uart_rx

Overview:
- Serial receiver paired with the team's 8N1 UART transmitter.
- Consumes the asynchronous line the transmitter drives (LSB first, one start bit, n data bits, one stop bit, idle high) and recovers parallel bytes.
- Uses mid-bit sampling from the system clock.
- Presents each byte with a ready/acknowledge hold register, plus framing-error and overrun status, to the downstream consumer (FIFO or controller).

Parameters:
- SEQ, 100000000, system clock frequency in Hz.
- BAUD_RATE, 9600, line bit rate.
- n, 8, data bits per frame.
- Derived localparams: t_baud = SEQ/BAUD_RATE (integer division); t_half = t_baud/2. Baud counter width is $clog2(t_baud).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line, idle high.
- rd_en  input  1  consumer acknowledge; clears rx_ready.
- data_out  output  n  last correctly framed byte.
- rx_ready  output  1  level: data_out holds an unread byte.
- rx_done  output  1  one-cycle pulse when a good frame is accepted.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- overrun  output  1  sticky; set when a good frame lands while rx_ready=1; cleared by rd_en.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Outputs: data_out=0, rx_ready=0, rx_done=0, frame_err=0, overrun=0, busy=0.
  - State=IDLE, counter=0, bit index=0.
  - Synchronizer flops preset to 1.
  - Reset mid-frame abandons the frame with no pulses.
- Input path: rx passes through a 2-flop synchronizer (rx_s). All decisions use rx_s only.
- IDLE:
  - When rx_s==0: enter START, counter=0.
- START:
  - Count to t_half-1, then sample rx_s.
  - rx_s==0: go to DATA, counter=0, index=0.
  - rx_s==1: glitch rejected; return to IDLE with no pulses.
- DATA:
  - Count to t_baud-1, then sample rx_s into shift register bit [index] (LSB first).
  - Counter clears each bit.
  - After index==n-1 is sampled, go to STOP.
- STOP:
  - Count to t_baud-1, then sample rx_s.
  - rx_s==1: data_out<=shift reg, rx_done pulse, rx_ready<=1. If rx_ready was already 1 and rd_en is not asserted that cycle, set overrun. Go to IDLE.
  - rx_s==0: frame_err pulse; data_out and rx_ready unchanged; go to BREAK.
- BREAK:
  - Wait until rx_s==1, then go to IDLE. A held-low line therefore yields exactly one frame_err.
- Sampling points and latency:
  - Counted from the first cycle rx_s==0: start check at +t_half, data bit k at +t_half+(k+1)*t_baud, stop at +t_half+(n+1)*t_baud.
  - rx_done/rx_ready are visible the cycle after the stop sample.
- Back-to-back frames: a new start bit is recognised immediately after returning to IDLE. Zero idle time between the transmitter's stop and next start is handled.
- rd_en:
  - Clears rx_ready and overrun on the next edge.
  - If rd_en coincides with a new good frame, the new frame wins: rx_ready stays 1 and overrun is not set.
- rd_en with rx_ready=0 has no effect.
- Default/illegal state returns to IDLE.

Decomposition:
- Shared package uart_pkg:
  - state encoding for IDLE/START/DATA/STOP/BREAK (3 bits);
  - a function computing t_baud from SEQ/BAUD_RATE, shared with the transmitter.
- One sub-module uart_sync: 2-flop synchronizer with parameterised reset value (here 1).
- Everything else stays in uart_rx.

Test Plan (SEQ=160, BAUD_RATE=10 → t_baud=16, t_half=8; bench drives rx at 16 clk/bit):
- Send 0xA5, good stop → exactly one rx_done pulse, data_out=0xA5, rx_ready=1, frame_err never high. rd_en for one cycle → rx_ready=0.
- Glitch: rx low for 4 cycles, then high → no pulses, busy returns to 0 within 10 cycles, data_out unchanged.
- Send 0x3C with stop bit low, then hold rx low for 40 cycles → one frame_err pulse; state stays BREAK until rx high; data_out/rx_ready unchanged. A following 0x81 frame is received correctly.
- Send 0x11 then 0x22 back-to-back without rd_en → data_out=0x22, overrun=1, rx_ready=1. rd_en clears both.
- rd_en asserted exactly in the cycle 0x22 completes (first byte pending) → rx_ready=1, overrun=0, data_out=0x22.
- rst pulsed in the middle of data bit 3 of 0xFF, then a clean 0x5A sent → no pulse for the aborted frame, data_out=0x5A after the second frame.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the 8N1 UART receiver and transmitter.
//   state_t      : receiver FSM encoding (3 bits)
//   calc_t_baud  : system clocks per serial bit, SEQ / BAUD_RATE (truncating)
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } state_t;

   function automatic int calc_t_baud(input int seq, input int baud_rate);
      return seq / baud_rate;
   endfunction

endpackage

// File: rtl/uart_sync.sv
// -----------------------------------------------------------------------------
// uart_sync
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
// Both flops load RST_VAL during reset so an idle line reads as idle.
// Ports:
//   clk : system clock
//   rst : synchronous, active-high reset
//   d   : asynchronous input
//   q   : synchronized output (two clk cycles of latency)
// -----------------------------------------------------------------------------
module uart_sync #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1-style serial receiver (n data bits, LSB first, one start, one stop bit)
// using mid-bit sampling from the system clock. Each good byte is held in
// data_out with a ready/acknowledge handshake.
// Ports:
//   clk       : system clock, all logic on rising edge
//   rst       : synchronous, active-high reset
//   rx        : asynchronous serial line, idle high
//   rd_en     : consumer acknowledge; clears rx_ready and overrun
//   data_out  : last correctly framed byte
//   rx_ready  : data_out holds an unread byte
//   rx_done   : one-cycle pulse when a good frame is accepted
//   frame_err : one-cycle pulse when the stop bit is sampled low
//   overrun   : sticky; a good frame landed while rx_ready was set
//   busy      : receiver is anywhere but IDLE
// -----------------------------------------------------------------------------
module uart_rx
   import uart_pkg::*;
#(
   parameter int SEQ       = 100000000,
   parameter int BAUD_RATE = 9600,
   parameter int n         = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         rx,
   input  logic         rd_en,
   output logic [n-1:0] data_out,
   output logic         rx_ready,
   output logic         rx_done,
   output logic         frame_err,
   output logic         overrun,
   output logic         busy
);

   localparam int t_baud = calc_t_baud(SEQ, BAUD_RATE);
   localparam int t_half = t_baud / 2;
   localparam int CNT_W  = (t_baud > 1) ? $clog2(t_baud) : 1;
   localparam int IDX_W  = (n > 1) ? $clog2(n) : 1;

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(t_half - 1);
   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(t_baud - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(n - 1);

   logic             rx_s;
   state_t           state,      state_next;
   logic [CNT_W-1:0] cnt,        cnt_next;
   logic [IDX_W-1:0] idx,        idx_next;
   logic [n-1:0]     shift,      shift_next;
   logic [n-1:0]     data_next;
   logic             ready_next, ovr_next, done_next, ferr_next;

   uart_sync #(
      .RST_VAL (1'b1)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rx_s)
   );

   // NOTE: every signal written here gets a default first so no path leaves
   // it unassigned; that is what keeps this block from inferring latches.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      idx_next   = idx;
      shift_next = shift;
      data_next  = data_out;
      ready_next = rx_ready;
      ovr_next   = overrun;
      done_next  = 1'b0;
      ferr_next  = 1'b0;

      // Acknowledge; a good frame completing this same cycle overrides below.
      if (rd_en) begin
         ready_next = 1'b0;
         ovr_next   = 1'b0;
      end

      case (state)
         ST_IDLE: begin
            cnt_next = '0;
            if (!rx_s) begin
               state_next = ST_START;
            end
         end

         ST_START: begin
            if (cnt == HALF_LAST) begin
               cnt_next = '0;
               idx_next = '0;
               // Line back high at mid-start: a glitch, not a frame.
               state_next = rx_s ? ST_IDLE : ST_DATA;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end

         ST_DATA: begin
            if (cnt == BAUD_LAST) begin
               cnt_next        = '0;
               shift_next[idx] = rx_s;
               if (idx == IDX_LAST) begin
                  idx_next   = '0;
                  state_next = ST_STOP;
               end else begin
                  idx_next = idx + 1'b1;
               end
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end

         ST_STOP: begin
            if (cnt == BAUD_LAST) begin
               cnt_next = '0;
               if (rx_s) begin
                  data_next  = shift;
                  done_next  = 1'b1;
                  ready_next = 1'b1;
                  if (rx_ready && !rd_en) begin
                     ovr_next = 1'b1;
                  end
                  state_next = ST_IDLE;
               end else begin
                  ferr_next  = 1'b1;
                  state_next = ST_BREAK;
               end
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end

         // Held-low line: wait for idle so it reports only one frame_err.
         ST_BREAK: begin
            cnt_next = '0;
            if (rx_s) begin
               state_next = ST_IDLE;
            end
         end

         default: begin
            cnt_next   = '0;
            idx_next   = '0;
            state_next = ST_IDLE;
         end
      endcase
   end

   // NOTE: registers use non-blocking assignments so every flop samples the
   // pre-edge values computed above, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         idx       <= '0;
         data_out  <= '0;
         rx_ready  <= 1'b0;
         rx_done   <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         idx       <= idx_next;
         data_out  <= data_next;
         rx_ready  <= ready_next;
         rx_done   <= done_next;
         frame_err <= ferr_next;
         overrun   <= ovr_next;
      end
   end

   // NOTE: the shift register has no reset: all n bits are rewritten during
   // DATA before data_out can ever load it, so its power-up value is never seen.
   always_ff @(posedge clk) begin
      shift <= shift_next;
   end

   assign busy = (state != ST_IDLE);

endmodule
